// File: rtl/apa102_pkg.sv
// rtl/apa102_pkg.sv - shared constants and state encoding for the APA102 stream receiver
package apa102_pkg;
  localparam int          START_ZEROS = 32;
  localparam int          WORD_BITS   = 32;
  localparam logic [2:0]  LED_HDR     = 3'b111;
  localparam logic [31:0] END_WORD    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {HUNT, ARMED, DATA} rx_state_t;
endpackage

// File: rtl/apa102_rx_sync.sv
// rtl/apa102_rx_sync.sv - sck/mosi synchroniser with sck rising-edge pulse and aligned mosi bit
module apa102_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_sck,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_mosi_bit
);
  logic [2:0] r_sck;
  logic [1:0] r_mosi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck  <= '0;
      r_mosi <= '0;
    end else begin
      r_sck  <= {r_sck[1:0], i_sck};
      r_mosi <= {r_mosi[0], i_mosi};
    end
  end

  // mosi is taken from the same synchroniser depth as the sck level that fires the edge
  assign o_sck_rise = r_sck[1] & ~r_sck[2];
  assign o_mosi_bit = r_mosi[1];
endmodule

// File: rtl/apa102_frame_rx.sv
// rtl/apa102_frame_rx.sv - APA102 frame decoder; APA102_RX_STATS_EN adds frame/error counters
module apa102_frame_rx
  import apa102_pkg::*;
#(
  parameter int MAX_LEDS    = 16,
  parameter int IDX_W       = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sck_in,
  input  logic             i_mosi_in,
  output logic             o_led_valid,
  output logic [IDX_W-1:0] o_led_idx,
  output logic [4:0]       o_led_bright,
  output logic [7:0]       o_led_blue,
  output logic [7:0]       o_led_green,
  output logic [7:0]       o_led_red,
  output logic             o_frame_done,
  output logic [IDX_W-1:0] o_frame_len,
  output logic             o_hdr_err,
  output logic             o_frame_abort
`ifdef APA102_RX_STATS_EN
  ,
  output logic [15:0]      o_frame_cnt,
  output logic [15:0]      o_err_cnt
`endif
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic             w_rise;
  logic             w_bit;
  logic [31:0]      w_word;

  rx_state_t        r_state, w_state_nxt;
  logic [5:0]       r_zero_cnt, w_zero_nxt;
  logic [5:0]       r_bit_cnt, w_bit_nxt;
  logic [30:0]      r_shift, w_shift_nxt;
  logic [IDX_W-1:0] r_led_cnt, w_led_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
  logic             w_led_valid, w_frame_done, w_hdr_err, w_abort;

  apa102_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_sck      (i_sck_in),
    .i_mosi     (i_mosi_in),
    .o_sck_rise (w_rise),
    .o_mosi_bit (w_bit)
  );

  assign w_word = {r_shift, w_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= HUNT;
      r_zero_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_led_cnt  <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_zero_cnt <= w_zero_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_led_cnt  <= w_led_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_zero_nxt   = r_zero_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_led_nxt    = r_led_cnt;
    w_tmo_nxt    = r_tmo_cnt;
    w_led_valid  = 1'b0;
    w_frame_done = 1'b0;
    w_hdr_err    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_rise) begin
          if (w_bit) begin
            w_zero_nxt = '0;
          end else if (r_zero_cnt < 6'(START_ZEROS)) begin
            w_zero_nxt = r_zero_cnt + 6'd1;
            if (r_zero_cnt == 6'(START_ZEROS - 1)) w_state_nxt = ARMED;
          end
        end
      end
      ARMED: begin
        // the first 1 after the start frame is bit 31 of LED word 0
        if (w_rise && w_bit) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 6'd1;
          w_shift_nxt = w_word[30:0];
          w_led_nxt   = '0;
          w_tmo_nxt   = '0;
        end
      end
      DATA: begin
        if (w_rise) begin
          w_tmo_nxt   = '0;
          w_shift_nxt = w_word[30:0];
          if (r_bit_cnt == 6'(WORD_BITS - 1)) begin
            w_bit_nxt = '0;
            if (w_word == END_WORD) begin
              w_frame_done = 1'b1;
              w_state_nxt  = HUNT;
              w_zero_nxt   = '0;
            end else if (w_word[31:29] == LED_HDR) begin
              if (r_led_cnt == IDX_W'(MAX_LEDS)) begin
                w_abort     = 1'b1;
                w_state_nxt = HUNT;
                w_zero_nxt  = '0;
              end else begin
                w_led_valid = 1'b1;
                w_led_nxt   = r_led_cnt + 1'b1;
              end
            end else begin
              // an all-zero word doubles as a fresh start frame
              w_hdr_err   = 1'b1;
              w_abort     = 1'b1;
              w_state_nxt = (w_word == 32'd0) ? ARMED : HUNT;
              w_zero_nxt  = '0;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + 6'd1;
          end
        end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = HUNT;
          w_zero_nxt  = '0;
          w_tmo_nxt   = '0;
        end else begin
          w_tmo_nxt = r_tmo_cnt + 1'b1;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_led_valid   <= 1'b0;
      o_led_idx     <= '0;
      o_led_bright  <= '0;
      o_led_blue    <= '0;
      o_led_green   <= '0;
      o_led_red     <= '0;
      o_frame_done  <= 1'b0;
      o_frame_len   <= '0;
      o_hdr_err     <= 1'b0;
      o_frame_abort <= 1'b0;
    end else begin
      o_led_valid   <= w_led_valid;
      o_frame_done  <= w_frame_done;
      o_hdr_err     <= w_hdr_err;
      o_frame_abort <= w_abort;
      if (w_led_valid) begin
        o_led_idx    <= r_led_cnt;
        o_led_bright <= w_word[28:24];
        o_led_blue   <= w_word[23:16];
        o_led_green  <= w_word[15:8];
        o_led_red    <= w_word[7:0];
      end
      if (w_frame_done) o_frame_len <= r_led_cnt;
    end
  end

`ifdef APA102_RX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      if (w_frame_done && o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (w_abort && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_apa102_frame_rx.sv
// tb/tb_apa102_frame_rx.sv - directed self-checking bench for apa102_frame_rx
module tb_apa102_frame_rx;
  localparam int SCK_HALF = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       led_valid, frame_done, hdr_err, frame_abort;
  logic [4:0] led_idx, frame_len, led_bright;
  logic [7:0] led_blue, led_green, led_red;
`ifdef APA102_RX_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0, n_hdr = 0, n_abort = 0, n_combo = 0;
  logic [4:0]  last_len = '0;
  logic [4:0]  idx_q[$];
  logic [28:0] word_q[$];

  apa102_frame_rx dut (
    .clk           (clk),
    .reset         (reset),
    .i_sck_in      (sck),
    .i_mosi_in     (mosi),
    .o_led_valid   (led_valid),
    .o_led_idx     (led_idx),
    .o_led_bright  (led_bright),
    .o_led_blue    (led_blue),
    .o_led_green   (led_green),
    .o_led_red     (led_red),
    .o_frame_done  (frame_done),
    .o_frame_len   (frame_len),
    .o_hdr_err     (hdr_err),
    .o_frame_abort (frame_abort)
`ifdef APA102_RX_STATS_EN
    ,
    .o_frame_cnt   (frame_cnt),
    .o_err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (led_valid) begin
      idx_q.push_back(led_idx);
      word_q.push_back({led_bright, led_blue, led_green, led_red});
    end
    if (frame_done) begin
      n_done++;
      last_len = frame_len;
    end
    if (hdr_err) n_hdr++;
    if (frame_abort) n_abort++;
    if ((int'(led_valid) + int'(frame_done) + int'(frame_abort)) > 1 || (hdr_err && !frame_abort))
      n_combo++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    repeat (SCK_HALF) @(posedge clk);
    sck = 1'b1;
    repeat (SCK_HALF) @(posedge clk);
    sck = 1'b0;
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic frame1(input int zeros);
    send_zeros(zeros);
    send_word(32'hF842_7AF4);
    send_word(32'hF800_50FF);
    send_word(32'hFFFF_FFFF);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    logic [31:0] w;
    int bad;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {led_valid, led_idx, led_bright, led_blue, led_green, led_red,
                       frame_done, frame_len, hdr_err, frame_abort}, 64'd0);
    reset = 1'b0;

    // test 1: basic two-LED frame
    frame1(40);
    chk("t1_led_count", idx_q.size(), 2);
    chk("t1_idx0", idx_q[0], 0);
    chk("t1_word0", word_q[0], {5'h18, 8'h42, 8'h7A, 8'hF4});
    chk("t1_idx1", idx_q[1], 1);
    chk("t1_word1", word_q[1], {5'h18, 8'h00, 8'h50, 8'hFF});
    chk("t1_done", n_done, 1);
    chk("t1_len", last_len, 2);
    chk("t1_abort", n_abort, 0);

    // test 2: bad header (leading 0 stays ARMED, word becomes 0xBE000000), then recovery
    send_zeros(32);
    send_word(32'h5F00_0000);
    send_bit(1'b0);
    repeat (8) @(posedge clk);
    chk("t2_hdr_err", n_hdr, 1);
    chk("t2_abort", n_abort, 1);
    chk("t2_no_led", idx_q.size(), 2);
    frame1(40);
    chk("t2_rec_count", idx_q.size(), 4);
    chk("t2_rec_idx0", idx_q[2], 0);
    chk("t2_rec_word1", word_q[3], {5'h18, 8'h00, 8'h50, 8'hFF});
    chk("t2_rec_done", n_done, 2);
    chk("t2_rec_len", last_len, 2);
`ifdef APA102_RX_STATS_EN
    chk("t6_frame_cnt", frame_cnt, 2);
    chk("t6_err_cnt", err_cnt, 1);
`endif

    // test 3: overflow on the 17th LED word
    send_zeros(32);
    for (int i = 0; i < 17; i++) send_word(32'hF8FF_FFFF);
    repeat (8) @(posedge clk);
    chk("t3_led_count", idx_q.size(), 20);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (idx_q[4 + i] !== 5'(i) || word_q[4 + i] !== {5'h18, 24'hFFFFFF}) bad++;
    chk("t3_idx_seq", bad, 0);
    chk("t3_abort", n_abort, 2);
    chk("t3_no_hdr", n_hdr, 1);
    chk("t3_no_done", n_done, 2);

    // test 4: only 31 zeros, never arms
    frame1(31);
    chk("t4_no_led", idx_q.size(), 20);
    chk("t4_no_done", n_done, 2);

    // test 5: timeout after 10 bits of word 0
    send_zeros(32);
    w = 32'hF842_7AF4;
    for (int i = 31; i >= 22; i--) send_bit(w[i]);
    repeat (4040) @(posedge clk);
    chk("t5_tmo_early", n_abort, 2);
    repeat (100) @(posedge clk);
    chk("t5_tmo_fired", n_abort, 3);
    repeat (860) @(posedge clk);
    chk("t5_tmo_once", n_abort, 3);

    // reset mid-word, then a clean frame decodes from idx0
    send_zeros(32);
    for (int i = 31; i >= 20; i--) send_bit(w[i]);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_reset_outs", {led_valid, led_idx, led_bright, led_blue, led_green, led_red,
                          frame_done, frame_len, hdr_err, frame_abort}, 64'd0);
    repeat (3) @(posedge clk);
    reset = 1'b0;
    frame1(40);
    chk("t5_post_count", idx_q.size(), 22);
    chk("t5_post_idx0", idx_q[20], 0);
    chk("t5_post_word0", word_q[20], {5'h18, 8'h42, 8'h7A, 8'hF4});
    chk("t5_post_done", n_done, 3);
    chk("t5_post_abort", n_abort, 3);
    chk("pulse_exclusive", n_combo, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
